// File: rtl/sync_gen_v2_pkg.sv
// Shared mode constants and source-select type for the sync_gen_v2 frame-sync generator.
package sync_pkg;

  localparam logic [1:0] MODE_INT   = 2'd0;
  localparam logic [1:0] MODE_WHEEL = 2'd1;
  localparam logic [1:0] MODE_EXT   = 2'd2;
  localparam logic [1:0] MODE_RSV   = 2'd3;

  typedef enum logic [1:0] {
    SRC_INT,
    SRC_WHEEL,
    SRC_EXT
  } src_e;

  // The reserved encoding falls back to the internal timer.
  function automatic src_e decode_mode(input logic [1:0] mode);
    case (mode)
      MODE_WHEEL: return SRC_WHEEL;
      MODE_EXT:   return SRC_EXT;
      default:    return SRC_INT;
    endcase
  endfunction

endpackage

// File: rtl/sync_gen_v2_if.sv
// Configuration, pin and status bundle between the register file / pins and sync_gen_v2.
interface sync_gen_v2_if #(
  parameter int TIMER_W = 32,
  parameter int DIV_W   = 16,
  parameter int HOLD_W  = 12,
  parameter int MISS_W  = 16
);
  logic               i_ch_a;
  logic               i_ch_b;
  logic               i_ext_trig;
  logic               i_sync_enabled;
  logic [1:0]         i_mode;
  logic [DIV_W-1:0]   i_int_period_us;
  logic [HOLD_W-1:0]  i_holdoff_us;
  logic [7:0]         i_wheel_add;
  logic [7:0]         i_frame_dec;
  logic               i_clr_counters;
  logic               o_sync;
  logic               o_dir;
  logic               o_quad_err;
  logic [TIMER_W-1:0] o_sync_counter;
  logic [MISS_W-1:0]  o_missed_count;
  logic [TIMER_W-1:0] o_way_meter;
  logic [TIMER_W-1:0] o_system_timer;

  modport master (
    output i_ch_a, i_ch_b, i_ext_trig, i_sync_enabled, i_mode, i_int_period_us,
           i_holdoff_us, i_wheel_add, i_frame_dec, i_clr_counters,
    input  o_sync, o_dir, o_quad_err, o_sync_counter, o_missed_count, o_way_meter,
           o_system_timer
  );

  modport slave (
    input  i_ch_a, i_ch_b, i_ext_trig, i_sync_enabled, i_mode, i_int_period_us,
           i_holdoff_us, i_wheel_add, i_frame_dec, i_clr_counters,
    output o_sync, o_dir, o_quad_err, o_sync_counter, o_missed_count, o_way_meter,
           o_system_timer
  );
endinterface

// File: rtl/sync_gen_v2_quad_decoder.sv
// x4 quadrature decoder with frame accumulator and signed way meter.
module quad_decoder #(
  parameter int WAY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ch_a,
  input  logic             i_ch_b,
  input  logic [7:0]       i_wheel_add,
  input  logic [7:0]       i_frame_dec,
  input  logic             i_clr,
  output logic             o_step_fwd,
  output logic             o_step_rev,
  output logic             o_frame,
  output logic             o_dir,
  output logic             o_err,
  output logic [WAY_W-1:0] o_way
);

  // [0],[1] synchronise the pin; [2] holds the previous synchronised level.
  logic [2:0]       a_q, a_d, b_q, b_d;
  logic [15:0]      acc_q, acc_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             a_chg, b_chg, fwd, rev, frame;
  logic [15:0]      sum;

  always_comb begin
    a_d   = {a_q[1:0], i_ch_a};
    b_d   = {b_q[1:0], i_ch_b};
    a_chg = a_q[1] ^ a_q[2];
    b_chg = b_q[1] ^ b_q[2];
    // Forward order is {a,b}: 00 -> 10 -> 11 -> 01 -> 00.
    fwd   = (a_chg ^ b_chg) & (a_chg ? (a_q[1] != b_q[1]) : (a_q[1] == b_q[1]));
    rev   = (a_chg ^ b_chg) & ~fwd;
    sum   = acc_q + {8'd0, i_wheel_add};
    frame = fwd & (i_frame_dec != 8'd0) & (sum >= {8'd0, i_frame_dec});
    acc_d = acc_q;
    way_d = way_q;
    dir_d = dir_q;
    err_d = err_q;
    if (fwd) begin
      dir_d = 1'b1;
      acc_d = frame ? sum - {8'd0, i_frame_dec} : sum;
      if (frame) way_d = way_q + 1'b1;
    end
    if (rev) begin
      dir_d = 1'b0;
      if (acc_q >= {8'd0, i_wheel_add}) begin
        acc_d = acc_q - {8'd0, i_wheel_add};
      end else begin
        acc_d = '0;
        if (acc_q != '0) way_d = way_q - 1'b1;
      end
    end
    if (a_chg & b_chg) err_d = 1'b1;
    if (i_clr) begin
      way_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      way_q <= '0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      way_q <= way_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end

  assign o_step_fwd = fwd;
  assign o_step_rev = rev;
  assign o_frame    = frame;
  assign o_dir      = dir_q;
  assign o_err      = err_q;
  assign o_way      = way_q;

endmodule

// File: rtl/sync_gen_v2.sv
// Frame-sync generator: 1 us timebase, selectable sync source, holdoff gate and counters.
module sync_gen_v2
  import sync_pkg::*;
#(
  parameter int CLK_MHZ = 100,
  parameter int TIMER_W = 32,
  parameter int DIV_W   = 16,
  parameter int HOLD_W  = 12,
  parameter int MISS_W  = 16
) (
  input logic          clk,
  input logic          rst,
  sync_gen_v2_if.slave bus
);

  localparam int PRESC_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0]   pcnt_q, pcnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0]         ext_q, ext_d;
  logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
  logic               hold_free_q, hold_free_d;
  logic               sync_q, sync_d;
  logic [TIMER_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [MISS_W-1:0]  miss_q, miss_d;

  logic tick, cand_int, cand_ext, cand_wheel, cand, hold_ok, emit, miss_inc;
  logic step_fwd, step_rev, frame;

  quad_decoder #(.WAY_W(TIMER_W)) u_quad (
    .clk        (clk),
    .rst        (rst),
    .i_ch_a     (bus.i_ch_a),
    .i_ch_b     (bus.i_ch_b),
    .i_wheel_add(bus.i_wheel_add),
    .i_frame_dec(bus.i_frame_dec),
    .i_clr      (bus.i_clr_counters),
    .o_step_fwd (step_fwd),
    .o_step_rev (step_rev),
    .o_frame    (frame),
    .o_dir      (bus.o_dir),
    .o_err      (bus.o_quad_err),
    .o_way      (bus.o_way_meter)
  );

  assign tick       = (presc_q == PRESC_W'(CLK_MHZ - 1));
  assign cand_wheel = frame & step_fwd & ~step_rev;

  always_comb begin
    // NOTE: every _d gets a default first, so no branch can leave it unassigned and infer a latch.
    presc_d  = tick ? '0 : presc_q + 1'b1;
    timer_d  = tick ? timer_q + 1'b1 : timer_q;
    mode_d   = bus.i_mode;
    pcnt_d   = pcnt_q;
    cand_int = 1'b0;
    if (bus.i_mode != mode_q) begin
      pcnt_d = '0;
    end else if (tick) begin
      if (bus.i_int_period_us == '0) begin
        pcnt_d = '0;
      end else if (pcnt_q >= bus.i_int_period_us - DIV_W'(1)) begin
        cand_int = 1'b1;
        pcnt_d   = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    ext_d    = {ext_q[1:0], bus.i_ext_trig};
    cand_ext = ext_q[1] & ~ext_q[2];

    case (decode_mode(bus.i_mode))
      SRC_WHEEL: cand = cand_wheel;
      SRC_EXT:   cand = cand_ext;
      default:   cand = cand_int;
    endcase

    // hold_free stays set from reset until the first sync, so that sync is never blocked.
    hold_ok     = hold_free_q | (hcnt_q == bus.i_holdoff_us);
    emit        = cand & bus.i_sync_enabled & hold_ok;
    miss_inc    = cand & bus.i_sync_enabled & ~hold_ok;
    hold_free_d = hold_free_q & ~emit;
    hcnt_d      = hcnt_q;
    if (emit)                            hcnt_d = '0;
    else if (tick && hcnt_q < bus.i_holdoff_us) hcnt_d = hcnt_q + 1'b1;
    else if (tick)                       hcnt_d = bus.i_holdoff_us;

    sync_d     = emit;
    sync_cnt_d = bus.i_clr_counters ? '0 : sync_cnt_q + TIMER_W'(emit);
    miss_d     = miss_q;
    if (bus.i_clr_counters)             miss_d = '0;
    else if (miss_inc && miss_q != '1)  miss_d = miss_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the values from before this edge.
    if (rst) begin
      presc_q     <= '0;
      timer_q     <= '0;
      pcnt_q      <= '0;
      mode_q      <= '0;
      ext_q       <= '0;
      hcnt_q      <= '0;
      hold_free_q <= 1'b1;
      sync_q      <= 1'b0;
      sync_cnt_q  <= '0;
      miss_q      <= '0;
    end else begin
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      pcnt_q      <= pcnt_d;
      mode_q      <= mode_d;
      ext_q       <= ext_d;
      hcnt_q      <= hcnt_d;
      hold_free_q <= hold_free_d;
      sync_q      <= sync_d;
      sync_cnt_q  <= sync_cnt_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.o_sync         = sync_q;
  assign bus.o_sync_counter = sync_cnt_q;
  assign bus.o_missed_count = miss_q;
  assign bus.o_system_timer = timer_q;

endmodule

// File: tb/tb_sync_gen_v2.sv
// Directed self-checking bench for sync_gen_v2 at CLK_MHZ=4 (one tick every 4 clocks).
module tb_sync_gen_v2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   edge_n;
  int   pulse_cnt;
  int   p0;
  logic found;

  sync_gen_v2_if #(.TIMER_W(32), .DIV_W(16), .HOLD_W(12), .MISS_W(16)) bus ();

  sync_gen_v2 #(
    .CLK_MHZ(4), .TIMER_W(32), .DIV_W(16), .HOLD_W(12), .MISS_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_sync === 1'b1) pulse_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    edge_n += n;
  endtask

  task automatic fwd_step();
    if (bus.i_ch_a == bus.i_ch_b) bus.i_ch_a = ~bus.i_ch_a;
    else                          bus.i_ch_b = ~bus.i_ch_b;
  endtask

  task automatic rev_step();
    if (bus.i_ch_a == bus.i_ch_b) bus.i_ch_b = ~bus.i_ch_b;
    else                          bus.i_ch_a = ~bus.i_ch_a;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_sync"},   64'(bus.o_sync),         64'd0);
    check({pfx, "_cnt"},    64'(bus.o_sync_counter), 64'd0);
    check({pfx, "_missed"}, 64'(bus.o_missed_count), 64'd0);
    check({pfx, "_way"},    64'(bus.o_way_meter),    64'd0);
    check({pfx, "_timer"},  64'(bus.o_system_timer), 64'd0);
    check({pfx, "_dir"},    64'(bus.o_dir),          64'd0);
    check({pfx, "_err"},    64'(bus.o_quad_err),     64'd0);
  endtask

  int exp_wheel_cnt [8] = '{0, 0, 0, 1, 1, 1, 2, 2};
  int exp_ext_sync  [4] = '{1, 0, 0, 1};

  initial begin
    checks = 0; failures = 0; edge_n = 0; pulse_cnt = 0;
    rst = 1'b1;
    bus.i_ch_a = 1'b0; bus.i_ch_b = 1'b0; bus.i_ext_trig = 1'b0;
    bus.i_sync_enabled = 1'b1; bus.i_mode = 2'd0; bus.i_int_period_us = 16'd3;
    bus.i_holdoff_us = 12'd0; bus.i_wheel_add = 8'd3; bus.i_frame_dec = 8'd10;
    bus.i_clr_counters = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst = 1'b0;
    edge_n = 0;

    // Internal source, period 3 us: sync every 12 clocks, first at edge 12.
    step(11);
    check("int_pre", 64'(bus.o_sync), 64'd0);
    step(1);
    check("int_first", 64'(bus.o_sync), 64'd1);
    check("int_cnt1", 64'(bus.o_sync_counter), 64'd1);
    step(1);
    check("int_single", 64'(bus.o_sync), 64'd0);
    step(27);
    check("timer_40", 64'(bus.o_system_timer), 64'd10);
    check("int_cnt3", 64'(bus.o_sync_counter), 64'd3);

    // Wheel source: add 3, threshold 10 -> frames on forward steps 4 and 7.
    bus.i_mode = 2'd1;
    bus.i_clr_counters = 1'b1;
    step(1);
    bus.i_clr_counters = 1'b0;
    check("clr_cnt", 64'(bus.o_sync_counter), 64'd0);
    for (int i = 0; i < 8; i++) begin
      fwd_step();
      step(3);
      check($sformatf("wheel_sync%0d", i + 1), 64'(bus.o_sync), 64'((i == 3) || (i == 6)));
      step(1);
      check($sformatf("wheel_cnt%0d", i + 1), 64'(bus.o_sync_counter), 64'(exp_wheel_cnt[i]));
    end
    check("wheel_way", 64'(bus.o_way_meter), 64'd2);
    check("wheel_dir_fwd", 64'(bus.o_dir), 64'd1);
    // Accumulator 4 -> 1 -> underflow to 0, which backs the way meter off by one.
    rev_step(); step(4);
    rev_step(); step(4);
    check("rev_cnt", 64'(bus.o_sync_counter), 64'd2);
    check("rev_dir", 64'(bus.o_dir), 64'd0);
    check("rev_way", 64'(bus.o_way_meter), 64'd1);

    // Both channels toggle together: illegal transition.
    bus.i_ch_a = ~bus.i_ch_a;
    bus.i_ch_b = ~bus.i_ch_b;
    step(4);
    check("qerr_set", 64'(bus.o_quad_err), 64'd1);
    check("qerr_way", 64'(bus.o_way_meter), 64'd1);
    bus.i_clr_counters = 1'b1;
    step(1);
    bus.i_clr_counters = 1'b0;
    check("clr_err", 64'(bus.o_quad_err), 64'd0);
    check("clr_way", 64'(bus.o_way_meter), 64'd0);
    check("clr_cnt2", 64'(bus.o_sync_counter), 64'd0);
    step(9);
    check("timer_runs", 64'(bus.o_system_timer), 64'(edge_n / 4));

    // Ext pin, holdoff 5 us, edges 2 us apart: edges 1 and 4 pass, 2 and 3 are dropped.
    bus.i_mode = 2'd2;
    bus.i_holdoff_us = 12'd5;
    step(40);
    for (int i = 0; i < 4; i++) begin
      bus.i_ext_trig = 1'b1;
      step(3);
      check($sformatf("ext_sync%0d", i + 1), 64'(bus.o_sync), 64'(exp_ext_sync[i]));
      step(1);
      bus.i_ext_trig = 1'b0;
      step(4);
    end
    check("ext_cnt", 64'(bus.o_sync_counter), 64'd2);
    check("ext_missed", 64'(bus.o_missed_count), 64'd2);

    // Disabled: candidates neither emitted nor counted as missed.
    bus.i_sync_enabled = 1'b0;
    bus.i_mode = 2'd0;
    p0 = pulse_cnt;
    step(48);
    check("dis_pulses", 64'(pulse_cnt), 64'(p0));
    check("dis_missed", 64'(bus.o_missed_count), 64'd2);
    check("dis_cnt", 64'(bus.o_sync_counter), 64'd2);

    // Clear coincident with a sync: the clear wins.
    bus.i_holdoff_us = 12'd0;
    step(8);
    bus.i_sync_enabled = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(1);
      if (bus.o_sync === 1'b1) found = 1'b1;
    end
    check("sync_found", 64'(found), 64'd1);
    step(11);
    bus.i_clr_counters = 1'b1;
    step(1);
    bus.i_clr_counters = 1'b0;
    check("clr_coinc_sync", 64'(bus.o_sync), 64'd1);
    check("clr_coinc_cnt", 64'(bus.o_sync_counter), 64'd0);
    check("clr_coinc_missed", 64'(bus.o_missed_count), 64'd0);
    step(12);
    check("post_clr_sync", 64'(bus.o_sync), 64'd1);
    check("post_clr_cnt", 64'(bus.o_sync_counter), 64'd1);

    // Reset mid-period with holdoff 100: first sync still passes, second is dropped.
    bus.i_holdoff_us = 12'd100;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    edge_n = 0;
    check_reset_state("mid_rst");
    step(12);
    check("rst_first_sync", 64'(bus.o_sync), 64'd1);
    check("rst_first_cnt", 64'(bus.o_sync_counter), 64'd1);
    step(12);
    check("rst_second_sync", 64'(bus.o_sync), 64'd0);
    check("rst_second_missed", 64'(bus.o_missed_count), 64'd1);
    check("rst_timer", 64'(bus.o_system_timer), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
